// File: rtl/light_pen_decoder.sv
// -----------------------------------------------------------------------------
// light_pen_decoder
//
// Receive side of the LED-matrix scan. Watches the one-hot row/col strobes
// coming from the scan driver together with the light-pen photodiode. It
// reports the (row, col) of the LED that lit the pen, at most once per frame.
//
// Optional feature macro: LPD_PEN_LOST_EN
//   defined   : counts frames since the last qualified hit and raises pen_lost
//               once LOST_FRAMES frames have passed without one.
//   undefined : no counter; pen_lost is tied low.
//
// Parameters
//   FILT_CYCLES  consecutive synced pen-high cycles at one position (1..255)
//   LOST_FRAMES  hit-free frames before pen_lost asserts (feature build only)
//
// Ports
//   clk        system clock (same domain as the scan driver)
//   rst        asynchronous reset, active-high
//   led_row    one-hot row strobe from the scan driver
//   led_col    one-hot column strobe from the scan driver
//   pen_in     raw photodiode comparator, asynchronous, 1 = light seen
//   hit_ready  consumer accepts the pending hit this cycle
//   hit_valid  hit_row/hit_col hold a pending coordinate
//   hit_row    row index of the hit
//   hit_col    column index of the hit
//   hit_ovr    1-cycle pulse: qualified hit dropped, previous one still pending
//   frame_tick 1-cycle pulse: scan moved onto position (0,0)
//   pos_err    1-cycle pulse: strobes not one-hot at a position change
//   pen_lost   no hit for LOST_FRAMES frames (0 when the feature is off)
// -----------------------------------------------------------------------------
module light_pen_decoder #(
    parameter int FILT_CYCLES = 4,
    parameter int LOST_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] led_row,
    input  logic [7:0] led_col,
    input  logic       pen_in,
    input  logic       hit_ready,
    output logic       hit_valid,
    output logic [2:0] hit_row,
    output logic [2:0] hit_col,
    output logic       hit_ovr,
    output logic       frame_tick,
    output logic       pos_err,
    output logic       pen_lost
);

    localparam logic [7:0] FILT_MAX  = 8'(FILT_CYCLES);
    localparam logic [7:0] FILT_LAST = 8'(FILT_CYCLES - 1);

    typedef enum logic {
        ARM  = 1'b0,
        LOCK = 1'b1
    } state_t;

    logic       pen_m;
    logic       pen_s;
    logic [7:0] row_r;
    logic [7:0] col_r;
    logic [7:0] row_p;
    logic [7:0] col_p;
    logic [2:0] row_idx;
    logic [2:0] col_idx;
    logic       pos_ok;
    logic       pos_chg;
    logic [7:0] cnt;
    logic       cnt_run;
    logic       qual;
    logic       accept;
    logic       xfer;
    state_t     state;
    state_t     state_nxt;

    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Two-flop synchronizer for the asynchronous photodiode input.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, exactly like the hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pen_m <= 1'b0;
            pen_s <= 1'b0;
        end else begin
            pen_m <= pen_in;
            pen_s <= pen_m;
        end
    end

    // Current and previous registered strobes; all-zero is the "no position"
    // value after reset, so the first real position counts as a change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r <= 8'h00;
            col_r <= 8'h00;
            row_p <= 8'h00;
            col_p <= 8'h00;
        end else begin
            row_r <= led_row;
            col_r <= led_col;
            row_p <= row_r;
            col_p <= col_r;
        end
    end

    assign row_idx    = onehot_idx(row_r);
    assign col_idx    = onehot_idx(col_r);
    assign pos_ok     = $onehot(row_r) && $onehot(col_r);
    assign pos_chg    = (row_r != row_p) || (col_r != col_p);
    assign frame_tick = pos_chg && pos_ok && (row_idx == 3'd0) && (col_idx == 3'd0);
    assign pos_err    = pos_chg && !pos_ok;

    // Dwell filter: the first cycle at a new position never counts, so a pen
    // held across a position change always restarts from zero.
    assign cnt_run = !pos_chg && pos_ok && pen_s;
    assign qual    = cnt_run && (cnt == FILT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'h00;
        end else if (!cnt_run) begin
            cnt <= 8'h00;
        end else if (cnt != FILT_MAX) begin
            cnt <= cnt + 8'h01;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARM;
        else     state <= state_nxt;
    end

    // FSM: next state. frame_tick has priority over a simultaneous qual.
    // NOTE: state_nxt gets a default before any branch so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (frame_tick)                   state_nxt = ARM;
        else if (state == ARM && qual)    state_nxt = LOCK;
    end

    // FSM: output decode -- only the first qual of a frame is offered.
    always_comb begin
        accept = 1'b0;
        if (state == ARM && qual && !frame_tick) accept = 1'b1;
    end

    // Hit holding register with valid/ready handshake. A transfer in the same
    // cycle frees the slot, so a new hit can load without a gap.
    assign xfer = hit_valid && hit_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_valid <= 1'b0;
            hit_row   <= 3'd0;
            hit_col   <= 3'd0;
            hit_ovr   <= 1'b0;
        end else begin
            hit_ovr <= accept && hit_valid && !xfer;
            if (accept && (!hit_valid || xfer)) begin
                hit_valid <= 1'b1;
                hit_row   <= row_idx;
                hit_col   <= col_idx;
            end else if (xfer) begin
                hit_valid <= 1'b0;
            end
        end
    end

`ifdef LPD_PEN_LOST_EN
    localparam logic [7:0] LOST_MAX = 8'(LOST_FRAMES);

    logic [7:0] lost_cnt;

    // Counts frame starts since the last qual of any kind, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_cnt <= 8'h00;
        end else if (qual) begin
            lost_cnt <= 8'h00;
        end else if (frame_tick && lost_cnt != LOST_MAX) begin
            lost_cnt <= lost_cnt + 8'h01;
        end
    end

    assign pen_lost = (lost_cnt >= LOST_MAX);
`else
    logic unused_lost_frames;
    assign unused_lost_frames = (LOST_FRAMES != 0);
    assign pen_lost           = 1'b0;
`endif

endmodule

// File: tb/tb_light_pen_decoder.sv
// -----------------------------------------------------------------------------
// tb_light_pen_decoder
//
// Self-checking bench for light_pen_decoder (FILT_CYCLES=4, LOST_FRAMES=8).
// A behavioural model tracks, per clock, the synced view of the strobes and
// pen, the length of the current qualifying pen streak, whether this frame
// already produced a hit, the pending hit and the frames-since-hit count.
// Directed scenarios are followed by a randomized multi-frame scan.
// -----------------------------------------------------------------------------
module tb_light_pen_decoder;

    localparam int FILT = 4;
    localparam int LOST = 8;
`ifdef LPD_PEN_LOST_EN
    localparam bit LOST_EN = 1'b1;
`else
    localparam bit LOST_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] led_row;
    logic [7:0] led_col;
    logic       pen_in;
    logic       hit_ready;
    logic       hit_valid;
    logic [2:0] hit_row;
    logic [2:0] hit_col;
    logic       hit_ovr;
    logic       frame_tick;
    logic       pos_err;
    logic       pen_lost;

    int total = 0;
    int bad   = 0;

    light_pen_decoder #(.FILT_CYCLES(FILT), .LOST_FRAMES(LOST)) dut (
        .clk        (clk),
        .rst        (rst),
        .led_row    (led_row),
        .led_col    (led_col),
        .pen_in     (pen_in),
        .hit_ready  (hit_ready),
        .hit_valid  (hit_valid),
        .hit_row    (hit_row),
        .hit_col    (hit_col),
        .hit_ovr    (hit_ovr),
        .frame_tick (frame_tick),
        .pos_err    (pos_err),
        .pen_lost   (pen_lost)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] d_row, d_col;   // strobes driven for the previous edge
    logic       d_pen;          // pen driven for the previous edge
    logic       m_valid, m_locked, m_ovr;
    logic [2:0] m_row, m_col;
    logic       w_qual, w_tick, w_err;
    logic [2:0] w_row, w_col;
    int         m_streak, m_lost;
    logic       e_lost;

    function automatic logic [2:0] idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic model_reset();
        d_row = 8'h00; d_col = 8'h00; d_pen = 1'b0;
        m_valid = 1'b0; m_locked = 1'b0; m_ovr = 1'b0;
        m_row = 3'd0; m_col = 3'd0;
        w_qual = 1'b0; w_tick = 1'b0; w_err = 1'b0;
        w_row = 3'd0; w_col = 3'd0;
        m_streak = 0; m_lost = 0; e_lost = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge,
    // then let the edge happen and settle 1 ns after it.
    task automatic step(input logic [7:0] row, input logic [7:0] col,
                        input logic pen, input logic ready);
        logic xfer, acc, chg, oh;
        led_row = row; led_col = col; pen_in = pen; hit_ready = ready;
        // Edge: act on what was seen during the previous cycle.
        xfer  = m_valid && ready;
        acc   = w_qual && !m_locked && !w_tick;
        m_ovr = acc && m_valid && !xfer;
        if (acc && (!m_valid || xfer)) begin
            m_valid = 1'b1; m_row = w_row; m_col = w_col;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        if (w_tick)    m_locked = 1'b0;
        else if (acc)  m_locked = 1'b1;
        if (w_qual)                      m_lost = 0;
        else if (w_tick && m_lost < LOST) m_lost = m_lost + 1;
        e_lost = LOST_EN && (m_lost >= LOST);
        // After the edge: the registered strobes are these inputs, the synced
        // pen is the one driven a cycle earlier.
        chg      = (row != d_row) || (col != d_col);
        oh       = $onehot(row) && $onehot(col);
        w_tick   = chg && oh && row == 8'h01 && col == 8'h01;
        w_err    = chg && !oh;
        m_streak = (!chg && oh && d_pen) ? m_streak + 1 : 0;
        w_qual   = (m_streak == FILT);
        w_row    = idx(row);
        w_col    = idx(col);
        d_row = row; d_col = col; d_pen = pen;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++; if (hit_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %b want 0", hit_valid); end
        total++; if (hit_row !== 3'd0)    begin bad++; $display("FAIL reset_row: got %0d want 0", hit_row); end
        total++; if (hit_col !== 3'd0)    begin bad++; $display("FAIL reset_col: got %0d want 0", hit_col); end
        total++; if (hit_ovr !== 1'b0)    begin bad++; $display("FAIL reset_ovr: got %b want 0", hit_ovr); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        total++; if (pos_err !== 1'b0)    begin bad++; $display("FAIL reset_err: got %b want 0", pos_err); end
        total++; if (pen_lost !== 1'b0)   begin bad++; $display("FAIL reset_lost: got %b want 0", pen_lost); end
    endtask

    // Pen high at (2,5) for 8 cycles with ready held: exactly one hit cycle.
    task automatic test_basic_hit();
        int nvalid;
        logic [2:0] got_r, got_c;
        nvalid = 0; got_r = 3'd7; got_c = 3'd7;
        for (int i = 0; i < 8; i++) begin
            step(8'h04, 8'h20, 1'b1, 1'b1);
            total++;
            if (hit_valid !== m_valid) begin bad++; $display("FAIL basic_valid i=%0d: got %b want %b", i, hit_valid, m_valid); end
            if (hit_valid === 1'b1) begin nvalid++; got_r = hit_row; got_c = hit_col; end
        end
        total++; if (nvalid != 1)    begin bad++; $display("FAIL basic_count: got %0d want 1", nvalid); end
        total++; if (got_r !== 3'd2) begin bad++; $display("FAIL basic_row: got %0d want 2", got_r); end
        total++; if (got_c !== 3'd5) begin bad++; $display("FAIL basic_col: got %0d want 5", got_c); end
    endtask

    // Three synced pen cycles at (1,1), then a move to (1,2): the count must
    // restart, so the hit appears only after four fresh cycles at (1,2).
    task automatic test_filter_restart();
        for (int i = 0; i < 2; i++) step(8'h01, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i < 4) step(8'h02, 8'h02, 1'b1, 1'b0);
            else       step(8'h02, 8'h04, 1'b1, 1'b0);
            total++;
            if (hit_valid !== 1'b0) begin bad++; $display("FAIL restart_early i=%0d: got %b want 0", i, hit_valid); end
        end
        step(8'h02, 8'h04, 1'b1, 1'b0);
        total++; if (hit_valid !== 1'b1) begin bad++; $display("FAIL restart_valid: got %b want 1", hit_valid); end
        total++; if ({hit_row, hit_col} !== {3'd1, 3'd2}) begin bad++; $display("FAIL restart_pos: got %0d,%0d want 1,2", hit_row, hit_col); end
    endtask

    // Hit (1,2) still pending, next frame qualifies (3,4): overrun pulse,
    // pending coordinates untouched.
    task automatic test_overrun();
        int novr;
        novr = 0;
        for (int i = 0; i < 2; i++) step(8'h01, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(8'h08, 8'h10, 1'b1, 1'b0);
            total++;
            if (hit_ovr !== m_ovr) begin bad++; $display("FAIL ovr_model i=%0d: got %b want %b", i, hit_ovr, m_ovr); end
            if (hit_ovr === 1'b1) novr++;
        end
        total++; if (novr != 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", novr); end
        total++; if ({hit_valid, hit_row, hit_col} !== {1'b1, 3'd1, 3'd2}) begin
            bad++; $display("FAIL ovr_keep: got %b %0d,%0d want 1 1,2", hit_valid, hit_row, hit_col);
        end
    endtask

    // Transfer and a new qual on the same edge: valid stays high, new coords.
    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) step(8'h01, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h20, 8'h40, 1'b1, 1'b0);
        total++; if ({hit_valid, hit_row, hit_col} !== {1'b1, 3'd1, 3'd2}) begin
            bad++; $display("FAIL b2b_before: got %b %0d,%0d want 1 1,2", hit_valid, hit_row, hit_col);
        end
        step(8'h20, 8'h40, 1'b1, 1'b1);
        total++; if ({hit_valid, hit_row, hit_col} !== {1'b1, 3'd5, 3'd6}) begin
            bad++; $display("FAIL b2b_new: got %b %0d,%0d want 1 5,6", hit_valid, hit_row, hit_col);
        end
        total++; if (hit_ovr !== 1'b0) begin bad++; $display("FAIL b2b_ovr: got %b want 0", hit_ovr); end
        step(8'h20, 8'h40, 1'b1, 1'b1);
        total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", hit_valid); end
    endtask

    // Two-hot row strobe: one pos_err pulse, the pen never qualifies.
    task automatic test_pos_err();
        int nerr, nvalid;
        nerr = 0; nvalid = 0;
        for (int i = 0; i < 2; i++) step(8'h01, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(8'h03, 8'h04, 1'b1, 1'b1);
            total++;
            if (pos_err !== w_err) begin bad++; $display("FAIL err_model i=%0d: got %b want %b", i, pos_err, w_err); end
            if (pos_err === 1'b1) nerr++;
            if (hit_valid === 1'b1) nvalid++;
        end
        total++; if (nerr != 1)   begin bad++; $display("FAIL err_count: got %0d want 1", nerr); end
        total++; if (nvalid != 0) begin bad++; $display("FAIL err_hit: got %0d valid cycles want 0", nvalid); end
    endtask

    // Asynchronous reset while a hit is pending.
    task automatic test_rst_mid();
        for (int i = 0; i < 2; i++) step(8'h01, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(8'h10, 8'h10, 1'b1, 1'b0);
        total++; if ({hit_valid, hit_row, hit_col} !== {1'b1, 3'd4, 3'd4}) begin
            bad++; $display("FAIL rst_pre: got %b %0d,%0d want 1 4,4", hit_valid, hit_row, hit_col);
        end
        #2 rst = 1'b1;
        #2;
        total++; if ({hit_valid, hit_row, hit_col, hit_ovr, frame_tick, pos_err, pen_lost} !== 10'd0) begin
            bad++; $display("FAIL rst_outputs: got %b%b%b%b%b%b%b want all 0",
                            hit_valid, hit_row, hit_col, hit_ovr, frame_tick, pos_err, pen_lost);
        end
        #1 rst = 1'b0;
        model_reset();
        #1;
        total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL rst_release: got %b want 0", hit_valid); end
        for (int i = 0; i < 3; i++) begin
            step(8'h10, 8'h10, 1'b1, 1'b1);
            total++;
            if (hit_valid !== m_valid) begin bad++; $display("FAIL rst_after i=%0d: got %b want %b", i, hit_valid, m_valid); end
        end
    endtask

    // Eight hit-free frames raise pen_lost (feature build), a hit clears it.
    task automatic test_pen_lost();
        for (int fr = 0; fr < 8; fr++) begin
            for (int i = 0; i < 4; i++) begin
                if (i < 2) step(8'h01, 8'h01, 1'b0, 1'b1);
                else       step(8'h01, 8'h02, 1'b0, 1'b1);
                total++;
                if (pen_lost !== e_lost) begin bad++; $display("FAIL lost_model fr=%0d: got %b want %b", fr, pen_lost, e_lost); end
            end
            if (fr == 6) begin
                total++; if (pen_lost !== 1'b0) begin bad++; $display("FAIL lost_7frames: got %b want 0", pen_lost); end
            end
        end
        total++; if (pen_lost !== LOST_EN) begin bad++; $display("FAIL lost_8frames: got %b want %b", pen_lost, LOST_EN); end
        for (int i = 0; i < 2; i++) step(8'h01, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(8'h04, 8'h04, 1'b1, 1'b1);
        total++; if (pen_lost !== 1'b0) begin bad++; $display("FAIL lost_cleared: got %b want 0", pen_lost); end
    endtask

    // Random full-matrix scans: random dwell, pen target, noise, glitches
    // and consumer back-pressure, every output checked every cycle.
    task automatic test_random();
        logic [7:0] r, c;
        logic       pen, rdy;
        int         target, rmode, dwell;
        for (int f = 0; f < 5; f++) begin
            target = int'($urandom_range(0, 72));
            rmode  = int'($urandom_range(0, 2));
            for (int p = 0; p < 64; p++) begin
                r = 8'h01 << (p / 8);
                c = 8'h01 << (p % 8);
                if ($urandom_range(0, 40) == 0) r = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h00;
                dwell = (p == target) ? int'($urandom_range(4, 8)) : int'($urandom_range(1, 5));
                for (int d = 0; d < dwell; d++) begin
                    pen = (p == target) || ($urandom_range(0, 19) == 0);
                    rdy = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                    step(r, c, pen, rdy);
                    total++;
                    if ({hit_valid, hit_row, hit_col} !== {m_valid, m_row, m_col}) begin
                        bad++; $display("FAIL rnd_hit f=%0d p=%0d: got %b %0d,%0d want %b %0d,%0d",
                                        f, p, hit_valid, hit_row, hit_col, m_valid, m_row, m_col);
                    end
                    total++;
                    if (hit_ovr !== m_ovr) begin bad++; $display("FAIL rnd_ovr f=%0d p=%0d: got %b want %b", f, p, hit_ovr, m_ovr); end
                    total++;
                    if (frame_tick !== w_tick) begin bad++; $display("FAIL rnd_tick f=%0d p=%0d: got %b want %b", f, p, frame_tick, w_tick); end
                    total++;
                    if (pos_err !== w_err) begin bad++; $display("FAIL rnd_err f=%0d p=%0d: got %b want %b", f, p, pos_err, w_err); end
                    total++;
                    if (pen_lost !== e_lost) begin bad++; $display("FAIL rnd_lost f=%0d p=%0d: got %b want %b", f, p, pen_lost, e_lost); end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        led_row = 8'h00; led_col = 8'h00; pen_in = 1'b0; hit_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        test_reset();
        test_basic_hit();
        test_filter_restart();
        test_overrun();
        test_back_to_back();
        test_pos_err();
        test_rst_mid();
        test_pen_lost();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
